// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared types, RV32 load/store width codes and memory mode encodings
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] MODE_W = 2'b00;
  localparam logic [1:0] MODE_B = 2'b01;
  localparam logic [1:0] MODE_H = 2'b10;

  // Stores have no unsigned variants, so any store with bit2 set is illegal.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic r;
    case (f3[1:0])
      2'b01:   r = a[0];
      2'b10:   r = (a != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] f3_mode(input logic [2:0] f3);
    logic [1:0] m;
    case (f3[1:0])
      2'b00:   m = MODE_B;
      2'b01:   m = MODE_H;
      default: m = MODE_W;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_extend.sv
`default_nettype none
// ============================================================================
// Module   : lsu_load_extend
// Purpose  : Sign/zero extension of LSB-aligned load data by RV32 width code
// Revision : 1.0 - initial release
// ============================================================================
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_raw,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_raw;
    case (i_funct3)
      F3_B:    o_data = {{24{i_raw[7]}}, i_raw[7:0]};
      F3_H:    o_data = {{16{i_raw[15]}}, i_raw[15:0]};
      F3_BU:   o_data = {24'd0, i_raw[7:0]};
      F3_HU:   o_data = {16'd0, i_raw[15:0]};
      default: o_data = i_raw;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Single-outstanding RV32 load/store sequencer to a memory controller.
//            Define LSU_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYCLES.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_enable,
  output logic [23:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_instr_mode,
  input  logic [31:0] mem_rdata,
  input  logic        mem_op_r
);

  lsu_state_t  r_state;
  lsu_state_t  w_state_nxt;
  logic [2:0]  r_funct3;
  logic        w_accept;
  logic        w_bad;
  logic        w_done;
  logic        w_timeout;
  logic [31:0] w_ext;

  assign req_ready = (r_state == S_IDLE);
  assign w_accept  = req_ready && req_valid;
  assign w_bad     = f3_illegal(req_funct3, req_we) || f3_misaligned(req_funct3, req_addr[1:0]);
  assign w_done    = (r_state == S_WAIT) && mem_op_r;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_tmo_cnt;

  // Held at zero outside WAIT, so it is clear on every entry into WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_tmo_cnt <= '0;
    else if (r_state != S_WAIT) r_tmo_cnt <= '0;
    else                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  assign w_timeout = (r_state == S_WAIT) && !mem_op_r && (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] w_unused_tmo;
  assign w_unused_tmo = TIMEOUT_CYCLES;
  assign w_timeout    = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_bad ? S_RESP : S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (w_done || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  lsu_load_extend u_ext (
    .i_funct3 (r_funct3),
    .i_raw    (mem_rdata),
    .o_data   (w_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      mem_enable     <= 1'b0;
      mem_addr       <= '0;
      mem_we         <= 1'b0;
      mem_wdata      <= '0;
      mem_instr_mode <= MODE_W;
      r_funct3       <= '0;
    end else begin
      mem_enable <= (w_state_nxt == S_ISSUE);
      resp_valid <= (w_state_nxt == S_RESP);
      resp_err   <= (w_accept && w_bad) || w_timeout;
      resp_rdata <= (w_done && !mem_we) ? w_ext : '0;
      // Memory samples we/mode late, so the request stays on the bus until WAIT exits.
      if (w_accept && !w_bad) begin
        mem_addr       <= req_addr;
        mem_we         <= req_we;
        mem_wdata      <= req_wdata;
        mem_instr_mode <= f3_mode(req_funct3);
        r_funct3       <= req_funct3;
      end else if ((r_state == S_WAIT) && (w_state_nxt == S_RESP)) begin
        mem_we <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench for load_store_unit
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_enable;
  logic [23:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_instr_mode;
  logic [31:0] mem_rdata;
  logic        mem_op_r;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.TIMEOUT_CYCLES(15)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_enable     (mem_enable),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .mem_instr_mode (mem_instr_mode),
    .mem_rdata      (mem_rdata),
    .mem_op_r       (mem_op_r)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Legal access: accept, ISSUE, WAIT for wcyc cycles, then memory completes.
  task automatic access(input string tag, input logic we, input logic [2:0] f3,
                        input logic [23:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                        input int wcyc, input logic [1:0] mode, input logic [31:0] exp);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    check({tag, ".en"},    {31'd0, mem_enable}, 32'd1);
    check({tag, ".busy"},  {31'd0, req_ready},  32'd0);
    check({tag, ".addr"},  {8'd0, mem_addr},    {8'd0, addr});
    check({tag, ".we"},    {31'd0, mem_we},     {31'd0, we});
    check({tag, ".mode"},  {30'd0, mem_instr_mode}, {30'd0, mode});
    check({tag, ".wdata"}, mem_wdata, wd);
    tick();
    check({tag, ".en_off"}, {31'd0, mem_enable}, 32'd0);
    for (int i = 0; i < wcyc; i++) begin
      tick();
      check({tag, ".hold_we"}, {31'd0, mem_we}, {31'd0, we});
      check({tag, ".no_resp"}, {31'd0, resp_valid}, 32'd0);
    end
    mem_op_r = 1'b1; mem_rdata = rd;
    tick();
    mem_op_r = 1'b0; mem_rdata = '0;
    check({tag, ".rvalid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, ".rdata"},  resp_rdata, exp);
    check({tag, ".rerr"},   {31'd0, resp_err}, 32'd0);
    tick();
    check({tag, ".pulse"},  {31'd0, resp_valid}, 32'd0);
    check({tag, ".idle"},   {31'd0, req_ready},  32'd1);
  endtask

  task automatic bad_access(input string tag, input logic we, input logic [2:0] f3,
                            input logic [23:0] addr);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = 32'h5555_5555;
    tick();
    req_valid = 1'b0;
    check({tag, ".rvalid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, ".rerr"},   {31'd0, resp_err},   32'd1);
    check({tag, ".rdata"},  resp_rdata, 32'd0);
    check({tag, ".no_en"},  {31'd0, mem_enable}, 32'd0);
    tick();
    check({tag, ".pulse"},  {31'd0, resp_valid}, 32'd0);
    check({tag, ".no_en2"}, {31'd0, mem_enable}, 32'd0);
    check({tag, ".idle"},   {31'd0, req_ready},  32'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0;
    req_wdata = '0; mem_rdata = '0; mem_op_r = 1'b0;
    tick(); tick();
    check("rst.ready", {31'd0, req_ready},  32'd1);
    check("rst.rvalid", {31'd0, resp_valid}, 32'd0);
    check("rst.en",    {31'd0, mem_enable}, 32'd0);
    check("rst.we",    {31'd0, mem_we},     32'd0);
    check("rst.rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    access("lb",  1'b0, 3'b000, 24'h000010, 32'd0, 32'h0000_0080, 0, 2'b01, 32'hFFFF_FF80);
    access("lhu", 1'b0, 3'b101, 24'h000012, 32'd0, 32'h0000_ABCD, 1, 2'b10, 32'h0000_ABCD);
    access("lh",  1'b0, 3'b001, 24'h000012, 32'd0, 32'h0000_ABCD, 2, 2'b10, 32'hFFFF_ABCD);
    access("sw",  1'b1, 3'b010, 24'h000010, 32'hAABB_CCDD, 32'hDEAD_BEEF, 3, 2'b00, 32'd0);
    access("lw",  1'b0, 3'b010, 24'h000010, 32'd0, 32'hAABB_CCDD, 1, 2'b00, 32'hAABB_CCDD);
    access("lbu", 1'b0, 3'b100, 24'h000003, 32'd0, 32'h0000_00FF, 0, 2'b01, 32'h0000_00FF);
    access("sh",  1'b1, 3'b001, 24'h000012, 32'h0000_1234, 32'd0, 0, 2'b10, 32'd0);
    access("lb+", 1'b0, 3'b000, 24'h000011, 32'd0, 32'h0000_007F, 0, 2'b01, 32'h0000_007F);

    bad_access("lw_mis", 1'b0, 3'b010, 24'h000011);
    bad_access("lh_mis", 1'b0, 3'b001, 24'h000013);
    bad_access("f3_011", 1'b0, 3'b011, 24'h000010);
    bad_access("st_bu",  1'b1, 3'b100, 24'h000010);

    // Reset during WAIT, then a stray completion that must be ignored.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 24'h000040;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("rstw.ready",  {31'd0, req_ready},  32'd1);
    check("rstw.rvalid", {31'd0, resp_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    mem_op_r = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_op_r = 1'b0; mem_rdata = '0;
    check("rstw.late",   {31'd0, resp_valid}, 32'd0);
    check("rstw.idle",   {31'd0, req_ready},  32'd1);
    tick();
    check("rstw.late2",  {31'd0, resp_valid}, 32'd0);

    // req_valid held high while busy: exactly one response, next accept only from IDLE.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b100; req_addr = 24'h000020;
    tick();
    check("hold.en",   {31'd0, mem_enable}, 32'd1);
    tick();
    check("hold.en0",  {31'd0, mem_enable}, 32'd0);
    tick();
    check("hold.busy", {31'd0, req_ready},  32'd0);
    check("hold.en1",  {31'd0, mem_enable}, 32'd0);
    mem_op_r = 1'b1; mem_rdata = 32'h0000_00F0;
    tick();
    mem_op_r = 1'b0; mem_rdata = '0;
    check("hold.rvalid", {31'd0, resp_valid}, 32'd1);
    check("hold.rdata",  resp_rdata, 32'h0000_00F0);
    check("hold.en2",    {31'd0, mem_enable}, 32'd0);
    req_funct3 = 3'b001; req_addr = 24'h000022;
    tick();
    check("hold.one",    {31'd0, resp_valid}, 32'd0);
    check("hold.ready",  {31'd0, req_ready},  32'd1);
    tick();
    req_valid = 1'b0;
    check("hold2.en",    {31'd0, mem_enable}, 32'd1);
    check("hold2.addr",  {8'd0, mem_addr},    32'h0000_0022);
    check("hold2.mode",  {30'd0, mem_instr_mode}, 32'd2);
    tick();
    mem_op_r = 1'b1; mem_rdata = 32'h0000_8001;
    tick();
    mem_op_r = 1'b0; mem_rdata = '0;
    check("hold2.rdata", resp_rdata, 32'hFFFF_8001);
    tick();
    check("hold2.idle",  {31'd0, req_ready}, 32'd1);

`ifdef LSU_TIMEOUT_EN
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 24'h000030;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 14; i++) begin
      tick();
      check("tmo.wait", {31'd0, resp_valid}, 32'd0);
    end
    tick();
    check("tmo.rvalid", {31'd0, resp_valid}, 32'd1);
    check("tmo.rerr",   {31'd0, resp_err},   32'd1);
    check("tmo.rdata",  resp_rdata, 32'd0);
    tick();
    check("tmo.idle",   {31'd0, req_ready},  32'd1);
`else
    access("long", 1'b0, 3'b010, 24'h000030, 32'd0, 32'h0BAD_F00D, 25, 2'b00, 32'h0BAD_F00D);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15; maximum cycles in WAIT before abort (used only with LSU_TIMEOUT_EN).
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports, one per line:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core access request.
- req_ready  out  1  unit idle; accepts a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 width: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  in  24  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid: misaligned, illegal or timeout.
- mem_enable  out  1  one-cycle start pulse to the memory controller.
- mem_addr  out  24  address to memory.
- mem_we  out  1  write enable to memory.
- mem_wdata  out  32  data to memory.
- mem_instr_mode  out  2  00 word, 01 byte, 10 half.
- mem_rdata  in  32  memory read data; zero-extended; valid while mem_op_r=1.
- mem_op_r  in  1  memory operation done.

Function
REQ-004 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-005 IDLE: req_ready=1; a request is accepted when req_valid=1; addr, we, funct3 and wdata are latched.
REQ-006 On acceptance, SHALL go to RESP with resp_err=1 and issue no memory access if the request is illegal or misaligned.
- Illegal: funct3 011/110/111, or a store with funct3 bit2=1.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=00.
REQ-007 On acceptance of a legal, aligned request, SHALL go to ISSUE.
REQ-008 ISSUE: mem_enable=1 for exactly one cycle, then WAIT.
REQ-009 mem_addr, mem_we, mem_wdata and mem_instr_mode SHALL be driven from the latched values and held stable from ISSUE until leaving WAIT, because memory samples we and mode late.
REQ-010 WAIT: the first clock edge with mem_op_r=1 SHALL capture mem_rdata and move to RESP.
REQ-011 Load extension:
- lb/lh sign-extend from bit 7/15.
- lbu/lhu zero-extend.
- lw passes through unchanged.
REQ-012 RESP: resp_valid=1 for exactly one cycle, then IDLE; req_ready=0 in ISSUE, WAIT and RESP.
REQ-013 Latency: a legal access returns resp_valid exactly one cycle after mem_op_r is sampled; an error response comes one cycle after acceptance.
REQ-014 mem_op_r seen outside WAIT SHALL be ignored.
REQ-015 req_valid outside IDLE SHALL be ignored and not queued.
REQ-016 All outputs SHALL be registered except req_ready, which decodes the state.

Reset
REQ-017 rst_n low SHALL force IDLE and clear all outputs to 0, except req_ready=1 once in IDLE.
REQ-018 Reset mid-WAIT SHALL abandon the access; a late mem_op_r SHALL be ignored.

Configuration
REQ-019 With LSU_TIMEOUT_EN defined:
- A counter runs in WAIT; at TIMEOUT_CYCLES without mem_op_r, SHALL go to RESP with resp_err=1 and resp_rdata=0.
- The counter clears on entry to WAIT.
REQ-020 Without LSU_TIMEOUT_EN, WAIT SHALL be unbounded and no counter logic shall exist.

Structure
REQ-021 Package lsu_pkg SHALL hold:
- state enum;
- funct3 constants;
- mem_instr_mode encodings (MODE_W=00, MODE_B=01, MODE_H=10).
REQ-022 Sub-module lsu_load_extend (combinational: funct3, raw 32b -> extended 32b) SHALL be instantiated once.

Verification
REQ-023 lb, addr 0x10, memory byte 0x80 -> mem_instr_mode=01; resp_rdata=0xFFFFFF80; resp_err=0.
REQ-024 lhu, addr 0x12, memory 0x0000ABCD -> resp_rdata=0x0000ABCD; lh at the same address -> 0xFFFFABCD.
REQ-025 sw 0xAABBCCDD to 0x10, then lw from 0x10 -> resp_rdata=0xAABBCCDD; mem_we held 1 until mem_op_r.
REQ-026 lw at 0x11 -> resp_err=1 one cycle after acceptance; mem_enable never asserted.
REQ-027 Two cases:
- rst_n pulsed low during WAIT -> back in IDLE, req_ready=1, no resp_valid.
- With LSU_TIMEOUT_EN and mem_op_r tied 0 -> resp_err=1 after 15 WAIT cycles.
REQ-028 req_valid held high during a busy access -> exactly one response per accepted request; the next request is accepted only in IDLE.
